// File: rtl/xts_pkg.sv
// Shared definitions for the XTS sector engine.
//   xts_state_e : sequencer state encoding
//   GF_POLY     : reduction constant for multiply-by-alpha in GF(2^128)
//   gf_double   : tweak update T*alpha, integer bit convention
//                 (bit 127 is the x^127 coefficient; byte order is handled upstream)
package xts_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TWK_REQ,
    TWK_WAIT,
    DATA_WAIT,
    BLK_REQ,
    BLK_WAIT,
    OUT_HOLD,
    DONE
  } xts_state_e;

  localparam logic [127:0] GF_POLY = 128'h87;

  function automatic logic [127:0] gf_double(input logic [127:0] t);
    gf_double = {t[126:0], 1'b0} ^ (t[127] ? GF_POLY : 128'h0);
  endfunction

endpackage

// File: rtl/xts_tweak_reg.sv
// Holds the running XTS tweak T for the current sector.
//   clk, rst  : clock, synchronous active-high reset (T <= 0)
//   load      : capture load_val (the encrypted sector number, T0)
//   load_val  : new tweak value
//   dbl       : advance to the next block's tweak, T <= T*alpha
//   t         : current tweak
// load wins over dbl; the sequencer never asserts both in one cycle.
module xts_tweak_reg
  import xts_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] load_val,
  input  logic         dbl,
  output logic [127:0] t
);

  always_ff @(posedge clk) begin
    if (rst) begin
      t <= '0;
    end else if (load) begin
      t <= load_val;
    end else if (dbl) begin
      t <= gf_double(t);
    end
  end

endmodule

// File: rtl/xts_sector_engine.sv
// XTS sector engine: runs one sector of NUM_BLOCKS 128-bit blocks through an
// external iterative AES core.  T0 = E_K2(sector) is computed once per sector,
// then each block j produces out = AES_K1(in ^ Tj) ^ Tj and T advances by alpha.
//
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   start, dir, sector        : begin a sector (sampled in IDLE only); dir 0=enc 1=dec
//   in_valid/in_ready/in_data : input block stream
//   out_valid/out_ready/out_data/out_last : output block stream, last = block NUM_BLOCKS-1
//   busy                      : high whenever not IDLE
//   done                      : one-cycle pulse after the final output handshake
//   err                       : sticky AES timeout, cleared by rst or start
//   aes_req/aes_key_sel/aes_decrypt/aes_in : request to AES core (key_sel 1 = tweak key)
//   aes_done/aes_out          : AES completion pulse and result
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready are high.  The output side holds out_valid, out_data and
// out_last stable until that edge; in_ready is only high while waiting for a
// block, so no input is taken during tweak computation or output backpressure.
// aes_req is a one-cycle pulse; aes_in/aes_key_sel/aes_decrypt stay stable
// until aes_done, and aes_done is only honoured in the two WAIT states.
module xts_sector_engine
  import xts_pkg::*;
#(
  parameter int NUM_BLOCKS  = 32,
  parameter int AES_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dir,
  input  logic [127:0] sector,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         aes_req,
  output logic         aes_key_sel,
  output logic         aes_decrypt,
  output logic [127:0] aes_in,
  input  logic         aes_done,
  input  logic [127:0] aes_out
);

  localparam int CNT_W = $clog2(NUM_BLOCKS) + 1;
  localparam int TMO_W = $clog2(AES_TIMEOUT + 1);

  xts_state_e       state, state_nxt;
  logic [127:0]     sector_q, x_q, out_q, tweak;
  logic             dir_q, err_q;
  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;

  logic in_wait, tmo_hit, is_last, out_fire, twk_load, twk_dbl;

  assign in_wait  = (state == TWK_WAIT) || (state == BLK_WAIT);
  // A completion arriving in the final allowed cycle still counts as success.
  assign tmo_hit  = in_wait && !aes_done && (tmo == TMO_W'(AES_TIMEOUT - 1));
  assign is_last  = (cnt == CNT_W'(NUM_BLOCKS - 1));
  assign out_fire = (state == OUT_HOLD) && out_ready;
  assign twk_load = (state == TWK_WAIT) && aes_done;
  assign twk_dbl  = out_fire && !is_last;

  xts_tweak_reg u_tweak (
    .clk      (clk),
    .rst      (rst),
    .load     (twk_load),
    .load_val (aes_out),
    .dbl      (twk_dbl),
    .t        (tweak)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = TWK_REQ;
      TWK_REQ:   state_nxt = TWK_WAIT;
      TWK_WAIT: begin
        if (aes_done)     state_nxt = DATA_WAIT;
        else if (tmo_hit) state_nxt = IDLE;
      end
      DATA_WAIT: if (in_valid) state_nxt = BLK_REQ;
      BLK_REQ:   state_nxt = BLK_WAIT;
      BLK_WAIT: begin
        if (aes_done)     state_nxt = OUT_HOLD;
        else if (tmo_hit) state_nxt = IDLE;
      end
      OUT_HOLD:  if (out_ready) state_nxt = is_last ? DONE : DATA_WAIT;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    done        = 1'b0;
    aes_req     = 1'b0;
    aes_key_sel = 1'b0;
    aes_decrypt = 1'b0;
    busy        = (state != IDLE);
    case (state)
      TWK_REQ: begin
        aes_req     = 1'b1;
        aes_key_sel = 1'b1;
      end
      TWK_WAIT:  aes_key_sel = 1'b1;
      DATA_WAIT: in_ready = 1'b1;
      BLK_REQ: begin
        aes_req     = 1'b1;
        aes_decrypt = dir_q;
      end
      BLK_WAIT:  aes_decrypt = dir_q;
      OUT_HOLD: begin
        out_valid = 1'b1;
        out_last  = is_last;
      end
      DONE:      done = 1'b1;
      default: ;
    endcase
  end

  // The tweak is always encrypted, so only the operand differs between phases.
  assign aes_in   = ((state == TWK_REQ) || (state == TWK_WAIT)) ? sector_q : x_q;
  assign out_data = out_q;
  assign err      = err_q;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sector_q <= '0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      x_q      <= '0;
      out_q    <= '0;
      cnt      <= '0;
      tmo      <= '0;
    end else begin
      if (state == IDLE && start) begin
        sector_q <= sector;
        dir_q    <= dir;
        err_q    <= 1'b0;
      end
      if (tmo_hit) begin
        err_q <= 1'b1;
      end
      // Timeout counter restarts on every entry to a WAIT state.
      if (in_wait && !aes_done) begin
        tmo <= tmo + 1'b1;
      end else begin
        tmo <= '0;
      end
      if (twk_load) begin
        cnt <= '0;
      end else if (twk_dbl) begin
        cnt <= cnt + 1'b1;
      end
      if (state == DATA_WAIT && in_valid) begin
        x_q <= in_data ^ tweak;
      end
      if (state == BLK_WAIT && aes_done) begin
        out_q <= aes_out ^ tweak;
      end
    end
  end

endmodule

// File: tb/tb_xts_sector_engine.sv
// Directed + randomized bench for xts_sector_engine (NUM_BLOCKS=2 main
// instance, NUM_BLOCKS=1 second instance).  AES stubs return aes_in+1, or a
// forced tweak value for tweak-key requests when ovr_en is set.
module tb_xts_sector_engine;

  localparam int NB = 2;

  typedef struct packed {
    logic [127:0] din;
    logic         ks;
    logic         dec;
  } req_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic         start, dir, in_valid, out_ready;
  logic [127:0] sector, in_data;
  logic         in_ready, out_valid, out_last, busy, done, err;
  logic [127:0] out_data, aes_in;
  logic         aes_req, aes_key_sel, aes_decrypt;
  logic         aes_done;
  logic [127:0] aes_out;

  xts_sector_engine #(.NUM_BLOCKS(NB), .AES_TIMEOUT(64)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .sector(sector),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .err(err),
    .aes_req(aes_req), .aes_key_sel(aes_key_sel), .aes_decrypt(aes_decrypt),
    .aes_in(aes_in), .aes_done(aes_done), .aes_out(aes_out)
  );

  // ---------------- single-block DUT ----------------
  logic         start1;
  logic         in_ready1, out_valid1, out_last1, busy1, done1, err1;
  logic [127:0] out_data1, aes_in1;
  logic         aes_req1, aes_key_sel1, aes_decrypt1;
  logic         aes_done1;
  logic [127:0] aes_out1;

  xts_sector_engine #(.NUM_BLOCKS(1), .AES_TIMEOUT(64)) u_one (
    .clk(clk), .rst(rst), .start(start1), .dir(dir), .sector(sector),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_last(out_last1), .busy(busy1), .done(done1), .err(err1),
    .aes_req(aes_req1), .aes_key_sel(aes_key_sel1), .aes_decrypt(aes_decrypt1),
    .aes_in(aes_in1), .aes_done(aes_done1), .aes_out(aes_out1)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_q[$];
  logic [127:0] obs_q[$];
  req_t         req_q[$];
  req_t         got_req[$];
  logic [127:0] blk_data[NB];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Multiply by x modulo x^128 + x^7 + x^2 + x + 1.
  function automatic logic [127:0] mul_x(input logic [127:0] a);
    logic [128:0] p;
    p = {1'b0, a} << 1;
    if (p[128]) p = p ^ {1'b1, 120'd0, 8'h87};
    return p[127:0];
  endfunction

  // ---------------- AES stubs (sampled/driven on negedge) ----------------
  int           stub_lat  = 14;
  bit           stub_hang = 1'b0;
  bit           ovr_en    = 1'b0;
  logic [127:0] ovr_val   = '0;
  int           stub_cnt  = 0;
  logic [127:0] stub_res, stub_in;

  initial begin
    aes_done = 1'b0;
    aes_out  = '0;
  end

  always @(negedge clk) begin
    aes_done = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        aes_done = 1'b1;
        aes_out  = stub_res;
        if (busy) chk("aes_in_stable", aes_in, stub_in);
      end
    end
    if (aes_req) begin
      req_q.push_back('{aes_in, aes_key_sel, aes_decrypt});
      if (!stub_hang) begin
        stub_cnt = stub_lat;
        stub_in  = aes_in;
        stub_res = (ovr_en && aes_key_sel) ? ovr_val : aes_in + 128'd1;
      end
    end
  end

  int           cnt1  = 0;
  int           req1_n = 0;
  logic [127:0] res1;

  initial begin
    aes_done1 = 1'b0;
    aes_out1  = '0;
  end

  always @(negedge clk) begin
    aes_done1 = 1'b0;
    if (cnt1 > 0) begin
      cnt1--;
      if (cnt1 == 0) begin
        aes_done1 = 1'b1;
        aes_out1  = res1;
      end
    end
    if (aes_req1) begin
      req1_n++;
      cnt1 = 3;
      res1 = aes_in1 + 128'd1;
    end
  end

  // ---------------- driver: one full sector on the main DUT ----------------
  task automatic run_sector(input logic [127:0] sec, input logic d,
                            input int bp_lo, input int bp_hi, input bit chk_lat);
    logic [127:0] t, x, held;
    req_t exp_req[$];
    int k, bp, nreq;
    exp_q.delete();
    obs_q.delete();
    req_q.delete();
    got_req.delete();
    // Reference: expected AES requests and outputs for the whole sector.
    t = ovr_en ? ovr_val : sec + 128'd1;
    exp_req.push_back('{sec, 1'b1, 1'b0});
    for (int j = 0; j < NB; j++) begin
      x = blk_data[j] ^ t;
      exp_req.push_back('{x, 1'b0, d});
      exp_q.push_back((x + 128'd1) ^ t);
      t = mul_x(t);
    end

    start = 1'b1; sector = sec; dir = d;
    @(negedge clk);
    start = 1'b0; sector = rand128(); dir = ~d;
    chkb("busy_after_start", busy, 1'b1);
    chkb("err_after_start", err, 1'b0);

    for (int j = 0; j < NB; j++) begin
      in_valid = 1'b1; in_data = blk_data[j];
      k = 0;
      while (!in_ready && k < 300) begin @(negedge clk); k++; end
      chkb("in_ready_seen", k < 300, 1'b1);
      @(negedge clk);
      in_valid = 1'b0; in_data = rand128();
      k = 1;
      while (!out_valid && k < 300) begin @(negedge clk); k++; end
      chkb("out_valid_seen", k < 300, 1'b1);
      if (chk_lat) chk("latency", 128'(k), 128'(stub_lat + 2));
      bp = $urandom_range(bp_hi, bp_lo);
      held = out_data;
      nreq = req_q.size();
      repeat (bp) begin
        @(negedge clk);
        chk("bp_data_hold", out_data, held);
        chkb("bp_valid_hold", out_valid, 1'b1);
        chkb("bp_in_ready", in_ready, 1'b0);
      end
      chk("bp_no_req", 128'(req_q.size()), 128'(nreq));
      chk("out_data", out_data, exp_q.pop_front());
      obs_q.push_back(out_data);
      chkb("out_last", out_last, j == NB - 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (j == NB - 1) begin
        chkb("done_pulse", done, 1'b1);
        @(negedge clk);
        chkb("done_one_cycle", done, 1'b0);
        chkb("busy_end", busy, 1'b0);
      end else begin
        chkb("done_early", done, 1'b0);
      end
    end

    chk("req_count", 128'(req_q.size()), 128'(exp_req.size()));
    for (int i = 0; i < exp_req.size() && i < req_q.size(); i++) begin
      chk("req_aes_in", req_q[i].din, exp_req[i].din);
      chkb("req_key_sel", req_q[i].ks, exp_req[i].ks);
      chkb("req_decrypt", req_q[i].dec, exp_req[i].dec);
    end
    got_req = req_q;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k, wait_cyc;
    bit done_seen;
    rst = 1'b1;
    start = 1'b0; start1 = 1'b0; dir = 1'b0; sector = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_ctrl", 128'({in_ready, out_valid, out_last, busy, done, err,
                          aes_req, aes_key_sel, aes_decrypt}), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_aes_in", aes_in, '0);
    rst = 1'b0;
    @(negedge clk);

    // Basic sector: sector 5, inputs 3 then 0 -> outputs 0 then 1
    stub_lat = 14; ovr_en = 1'b0;
    blk_data[0] = 128'd3; blk_data[1] = 128'd0;
    run_sector(128'd5, 1'b0, 0, 0, 1'b1);
    chk("basic_out0", obs_q.size() > 0 ? obs_q[0] : 128'hx, 128'd0);
    chk("basic_out1", obs_q.size() > 1 ? obs_q[1] : 128'hx, 128'd1);
    chk("basic_twk_req", got_req.size() > 0 ? got_req[0].din : 128'hx, 128'd5);

    // GF doubling with the top bit set: T0 = 2^127 -> T1 = 0x87
    ovr_en = 1'b1; ovr_val = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
    blk_data[0] = 128'd0; blk_data[1] = 128'd0;
    run_sector(128'd7, 1'b0, 0, 0, 1'b0);
    chk("gf_wrap", got_req.size() > 2 ? got_req[2].din : 128'hx, 128'h87);

    // GF doubling without wrap: T0 = 1 -> T1 = 2
    ovr_val = 128'd1;
    run_sector(128'd8, 1'b0, 0, 0, 1'b0);
    chk("gf_shift", got_req.size() > 2 ? got_req[2].din : 128'hx, 128'd2);

    // Decrypt direction
    ovr_en = 1'b0;
    blk_data[0] = rand128(); blk_data[1] = rand128();
    run_sector(rand128(), 1'b1, 0, 2, 1'b0);
    chkb("dec_twk_req", got_req.size() > 0 ? got_req[0].dec : 1'bx, 1'b0);
    chkb("dec_blk_req", got_req.size() > 1 ? got_req[1].dec : 1'bx, 1'b1);

    // Output backpressure for 10 cycles on every block
    blk_data[0] = rand128(); blk_data[1] = rand128();
    run_sector(rand128(), 1'b0, 10, 10, 1'b0);

    // AES never answers: timeout after 64 cycles in TWK_WAIT
    stub_hang = 1'b1;
    req_q.delete();
    start = 1'b1; sector = 128'd11;
    @(negedge clk);
    start = 1'b0;
    k = 0; wait_cyc = 0; done_seen = 1'b0;
    while (busy && k < 200) begin
      if (!aes_req) wait_cyc++;
      if (done) done_seen = 1'b1;
      @(negedge clk);
      k++;
    end
    chkb("tmo_bounded", k < 200, 1'b1);
    chk("tmo_cycles", 128'(wait_cyc), 128'd64);
    chkb("tmo_err", err, 1'b1);
    chkb("tmo_busy", busy, 1'b0);
    chkb("tmo_no_done", done_seen, 1'b0);
    repeat (3) @(negedge clk);
    chkb("tmo_err_sticky", err, 1'b1);
    stub_hang = 1'b0;
    blk_data[0] = rand128(); blk_data[1] = rand128();
    run_sector(rand128(), 1'b0, 0, 1, 1'b0);   // start clears err

    // Reset during BLK_WAIT; the late aes_done must be ignored
    stub_lat = 14;
    req_q.delete();
    start = 1'b1; sector = 128'd21; dir = 1'b0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 128'd9;
    k = 0;
    while (!in_ready && k < 300) begin @(negedge clk); k++; end
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (req_q.size() < 2 && k < 300) begin @(negedge clk); k++; end
    chkb("rst_test_blk_req", req_q.size() == 2, 1'b1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_ctrl", 128'({in_ready, out_valid, out_last, busy, done, err,
                              aes_req, aes_key_sel, aes_decrypt}), '0);
      chk("abort_out_data", out_data, '0);
    end
    req_q.delete();

    // NUM_BLOCKS=1: first output is last, T0 used as-is
    begin
      logic [127:0] t0, d0;
      req1_n = 0;
      t0 = 128'd10;
      d0 = rand128();
      start1 = 1'b1; sector = 128'd9; dir = 1'b0;
      @(negedge clk);
      start1 = 1'b0;
      in_valid = 1'b1; in_data = d0;
      k = 0;
      while (!in_ready1 && k < 100) begin @(negedge clk); k++; end
      chkb("one_in_ready", k < 100, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid1 && k < 100) begin @(negedge clk); k++; end
      chkb("one_out_valid", k < 100, 1'b1);
      chkb("one_out_last", out_last1, 1'b1);
      chk("one_out_data", out_data1, ((d0 ^ t0) + 128'd1) ^ t0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chkb("one_done", done1, 1'b1);
      @(negedge clk);
      chkb("one_idle", busy1, 1'b0);
      chk("one_req_count", 128'(req1_n), 128'd2);
    end

    // Randomized sectors
    for (int s = 0; s < 6; s++) begin
      stub_lat = $urandom_range(20, 2);
      ovr_en   = 1'($urandom_range(1, 0));
      ovr_val  = rand128();
      for (int j = 0; j < NB; j++) blk_data[j] = rand128();
      run_sector(rand128(), 1'($urandom_range(1, 0)), 0, 5, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
